// File: rtl/byte_stream_arbiter.sv
// byte_stream_arbiter
// Shares one 512-bit block-to-byte extraction path between two requesters
// (0: CPU load port, 1: victim-cache probe/writeback). One request is accepted
// at a time under round-robin arbitration. The winner's 64-byte block is latched,
// then a burst of bytes is streamed from a starting offset, wrapping modulo 64,
// over a valid/ready output handshake.
//
// Ports:
//   clk                       system clock, rising edge
//   reset                     synchronous active-high reset
//   req_valid[1:0]            per-requester request valid
//   req_ready[1:0]            per-requester accept (combinational grant in IDLE)
//   req_block0/1[511:0]       block data per requester
//   req_offset0/1[5:0]        starting byte offset per requester
//   req_len0/1[5:0]           burst length, 0 encodes 64
//   out_valid / out_ready     output byte handshake
//   out_byte[7:0]             current byte
//   out_id                    requester owning the current burst
//   out_last                  current byte ends the burst
//   busy                      high while streaming
module byte_stream_arbiter (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [511:0] req_block0,
  input  logic [511:0] req_block1,
  input  logic [5:0]   req_offset0,
  input  logic [5:0]   req_offset1,
  input  logic [5:0]   req_len0,
  input  logic [5:0]   req_len1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_byte,
  output logic         out_id,
  output logic         out_last,
  output logic         busy
);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  state_e       state_q;
  logic         rr_ptr_q;
  logic [511:0] blk_q;
  logic [5:0]   off_q;
  logic [6:0]   rem_q;
  logic         out_id_q;

  logic         grant_sel;
  logic         req_fire;
  logic [511:0] win_block;
  logic [5:0]   win_off;
  logic [5:0]   win_len;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    grant_sel = (&req_valid) ? rr_ptr_q : req_valid[1];
    req_ready = 2'b00;
    if ((state_q == StIdle) && (|req_valid)) begin
      req_ready = grant_sel ? 2'b10 : 2'b01;
    end
  end

  assign req_fire  = |(req_valid & req_ready);
  assign win_block = grant_sel ? req_block1  : req_block0;
  assign win_off   = grant_sel ? req_offset1 : req_offset0;
  assign win_len   = grant_sel ? req_len1    : req_len0;

  // Outputs depend only on registered state, never on req_* inputs.
  assign out_valid = (state_q == StStream);
  assign busy      = (state_q == StStream);
  assign out_byte  = blk_q[{off_q, 3'b000} +: 8];
  assign out_last  = (state_q == StStream) && (rem_q == 7'd1);
  assign out_id    = out_id_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      rr_ptr_q <= 1'b0;
      blk_q    <= '0;
      off_q    <= '0;
      rem_q    <= '0;
      out_id_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_fire) begin
            blk_q    <= win_block;
            off_q    <= win_off;
            rem_q    <= (win_len == 6'd0) ? 7'd64 : {1'b0, win_len};
            out_id_q <= grant_sel;
            rr_ptr_q <= ~grant_sel;
            state_q  <= StStream;
          end
        end
        StStream: begin
          if (out_ready) begin
            off_q <= off_q + 6'd1;  // natural 6-bit wrap 63 -> 0
            rem_q <= rem_q - 7'd1;
            if (rem_q == 7'd1) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_stream_arbiter.sv
module tb_byte_stream_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [511:0] req_block0, req_block1;
  logic [5:0]   req_offset0, req_offset1;
  logic [5:0]   req_len0, req_len1;
  logic         out_valid, out_ready;
  logic [7:0]   out_byte;
  logic         out_id, out_last, busy;

  int errors = 0;
  int checks = 0;

  byte_stream_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_block0 (req_block0),
    .req_block1 (req_block1),
    .req_offset0(req_offset0),
    .req_offset1(req_offset1),
    .req_len0   (req_len0),
    .req_len1   (req_len1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .out_id     (out_id),
    .out_last   (out_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Block whose byte k holds value k.
  function automatic logic [511:0] ramp();
    logic [511:0] b;
    for (int k = 0; k < 64; k++) b[8*k +: 8] = 8'(k);
    return b;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (out_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", out_byte); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
    checks++; if (out_id !== 1'b0) begin errors++; $display("FAIL reset_id got %b want 0", out_id); end
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready_none got %b want 00", req_ready); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL reset_ready_both got %b want 01", req_ready); end
    req_valid = 2'b00;
    reset = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_offset0 = 6'd0; req_len0 = 6'd4; req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", req_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      checks++; if (out_valid !== 1'b1 || out_byte !== 8'(i) || out_id !== 1'b0 || out_last !== (i == 3))
        begin errors++; $display("FAIL single_byte%0d got v=%b b=%h id=%b l=%b want v=1 b=%h id=0 l=%b",
          i, out_valid, out_byte, out_id, out_last, 8'(i), (i == 3)); end
    end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0)
      begin errors++; $display("FAIL single_idle got busy=%b v=%b want 0 0", busy, out_valid); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_b [4] = '{8'h3E, 8'h3F, 8'h00, 8'h01};
    @(negedge clk);
    req_offset1 = 6'd62; req_len1 = 6'd4; req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL wrap_ready got %b want 10", req_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      checks++; if (out_valid !== 1'b1 || out_byte !== exp_b[i] || out_id !== 1'b1 || out_last !== (i == 3))
        begin errors++; $display("FAIL wrap_byte%0d got v=%b b=%h id=%b l=%b want v=1 b=%h id=1 l=%b",
          i, out_valid, out_byte, out_id, out_last, exp_b[i], (i == 3)); end
    end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_contention();
    logic [1:0] e_rdy [10] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [7:0] e_byte [10] = '{8'h00, 8'h10, 8'h11, 8'h00, 8'h20, 8'h21, 8'h00, 8'h10, 8'h11, 8'h00};
    logic [9:0] e_vld  = 10'b0110110110;
    logic [9:0] e_id   = 10'b0000110000;
    logic [9:0] e_last = 10'b0100100100;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req_offset0 = 6'h10; req_len0 = 6'd2;
    req_offset1 = 6'h20; req_len1 = 6'd2;
    req_valid = 2'b11;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (req_ready !== e_rdy[c] || out_valid !== e_vld[c])
        begin errors++; $display("FAIL cont_c%0d got rdy=%b v=%b want rdy=%b v=%b",
          c, req_ready, out_valid, e_rdy[c], e_vld[c]); end
      if (e_vld[c]) begin
        checks++; if (out_byte !== e_byte[c] || out_id !== e_id[c] || out_last !== e_last[c])
          begin errors++; $display("FAIL cont_data_c%0d got b=%h id=%b l=%b want b=%h id=%b l=%b",
            c, out_byte, out_id, out_last, e_byte[c], e_id[c], e_last[c]); end
      end
      if (c == 8) req_valid = 2'b00;
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_offset0 = 6'd5; req_len0 = 6'd3; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checks++; if (out_valid !== 1'b1 || out_byte !== 8'h05)
      begin errors++; $display("FAIL bp_first got v=%b b=%h want 1 05", out_valid, out_byte); end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b1 || out_byte !== 8'h05 || out_last !== 1'b0)
        begin errors++; $display("FAIL bp_hold%0d got v=%b b=%h l=%b want 1 05 0",
          i, out_valid, out_byte, out_last); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out_byte !== 8'h06 || out_last !== 1'b0)
      begin errors++; $display("FAIL bp_resume got v=%b b=%h l=%b want 1 06 0", out_valid, out_byte, out_last); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out_byte !== 8'h07 || out_last !== 1'b1)
      begin errors++; $display("FAIL bp_last got v=%b b=%h l=%b want 1 07 1", out_valid, out_byte, out_last); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_len0();
    int bad = 0;
    logic [5:0] exp_off;
    @(negedge clk);
    req_offset0 = 6'd10; req_len0 = 6'd0; req_valid = 2'b01;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      exp_off = 6'(10 + i);
      checks++; if (out_valid !== 1'b1 || out_byte !== {2'b00, exp_off} || out_last !== (i == 63))
        begin errors++; bad++;
          if (bad < 5) $display("FAIL len0_byte%0d got v=%b b=%h l=%b want v=1 b=%h l=%b",
            i, out_valid, out_byte, out_last, {2'b00, exp_off}, (i == 63)); end
    end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_offset0 = 6'd0; req_len0 = 6'd8; req_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      checks++; if (out_byte !== 8'(i)) begin errors++; $display("FAIL rmid_byte%0d got %h want %h", i, out_byte, 8'(i)); end
    end
    reset = 1'b1;
    req_offset0 = 6'h30; req_len0 = 6'd1;
    req_offset1 = 6'h31; req_len1 = 6'd1;
    req_valid = 2'b11;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_byte !== 8'h00 || out_last !== 1'b0)
      begin errors++; $display("FAIL rmid_cleared got v=%b busy=%b b=%h l=%b want 0 0 00 0",
        out_valid, busy, out_byte, out_last); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_prio got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b10;
    #1;
    checks++; if (out_valid !== 1'b1 || out_byte !== 8'h30 || out_id !== 1'b0 || out_last !== 1'b1)
      begin errors++; $display("FAIL rmid_r0 got v=%b b=%h id=%b l=%b want 1 30 0 1",
        out_valid, out_byte, out_id, out_last); end
    @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || req_ready !== 2'b10)
      begin errors++; $display("FAIL rmid_gap got v=%b rdy=%b want 0 10", out_valid, req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    checks++; if (out_valid !== 1'b1 || out_byte !== 8'h31 || out_id !== 1'b1 || out_last !== 1'b1)
      begin errors++; $display("FAIL rmid_r1 got v=%b b=%h id=%b l=%b want 1 31 1 1",
        out_valid, out_byte, out_id, out_last); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle got busy=%b want 0", busy); end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    req_block0 = ramp();
    req_block1 = ramp();
    req_offset0 = '0; req_offset1 = '0;
    req_len0 = '0; req_len1 = '0;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_backpressure();
    test_len0();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
